// File: rtl/conv_dp_pkg.sv
// Shared definitions for the 3x3 conv datapath: command/interrupt bit indices,
// default widths and the one-hot command decode.
package conv_dp_pkg;

    localparam int CMD_WAIT   = 0;
    localparam int CMD_READ_W = 1;
    localparam int CMD_READ   = 2;
    localparam int CMD_OPT    = 3;
    localparam int CMD_WRITE  = 4;
    localparam int CMD_END    = 5;
    localparam int CMD_FLAG_W = 6;

    localparam int INT_READ_W = 0;
    localparam int INT_READ   = 1;
    localparam int INT_OPT    = 2;
    localparam int INT_WRITE  = 3;
    localparam int INT_FLAG_W = 4;

    localparam int DEF_IMG_SIZE  = 64;
    localparam int DEF_GLB_CNT_W = 6;
    localparam int DEF_ACC_W     = 20;
    localparam int DEF_DATA_W    = 8;

    localparam int CNT_W    = 4;
    localparam int CNT_LAST = 9;

    typedef enum logic [2:0] {
        PH_ILLEGAL,
        PH_WAIT,
        PH_READ_W,
        PH_READ,
        PH_OPT,
        PH_WRITE,
        PH_END
    } phase_e;

    // Zero-hot and multi-hot commands both collapse to PH_ILLEGAL.
    function automatic phase_e decode_cmd(input logic [CMD_FLAG_W-1:0] cmd);
        phase_e ph;
        ph = PH_ILLEGAL;
        if ($onehot(cmd)) begin
            if (cmd[CMD_WAIT])        ph = PH_WAIT;
            else if (cmd[CMD_READ_W]) ph = PH_READ_W;
            else if (cmd[CMD_READ])   ph = PH_READ;
            else if (cmd[CMD_OPT])    ph = PH_OPT;
            else if (cmd[CMD_WRITE])  ph = PH_WRITE;
            else                      ph = PH_END;
        end
        return ph;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Unsigned-pixel x signed-weight multiply-accumulate with saturating output.
// CONV_RELU_EN selects ReLU + unsigned saturation; default is signed saturation.
module conv_mac
    import conv_dp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic [DATA_W-1:0]        pix,
    input  logic signed [DATA_W-1:0] wgt,
    output logic signed [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0]        sat
);

    localparam int PROD_W = 2 * DATA_W + 1;

`ifdef CONV_RELU_EN
    localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((1 << DATA_W) - 1);

    function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a < 0)         return '0;
        else if (a > UMAX) return '1;
        else               return a[DATA_W-1:0];
    endfunction
`else
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(1 << (DATA_W - 1)));

    function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > SMAX)      return {1'b0, {(DATA_W-1){1'b1}}};
        else if (a < SMIN) return {1'b1, {(DATA_W-1){1'b0}}};
        else               return a[DATA_W-1:0];
    endfunction
`endif

    logic signed [PROD_W-1:0] pix_s;
    logic signed [PROD_W-1:0] wgt_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    always_comb begin
        pix_s    = PROD_W'($signed({1'b0, pix}));
        wgt_s    = PROD_W'(wgt);
        prod     = pix_s * wgt_s;
        prod_ext = ACC_W'(prod);
        sat      = saturate(acc);
    end

    // Accumulator stage: clr loads the first product rather than zero.
    always_ff @(posedge clk) begin
        if (reset)    acc <= '0;
        else if (clr) acc <= prod_ext;
        else if (en)  acc <= acc + prod_ext;
    end

endmodule

// File: rtl/conv_dp.sv
// 3x3 convolution datapath driven by the controller's one-hot command stream.
// Output saturation mode is chosen by CONV_RELU_EN inside conv_mac.
module conv_dp
    import conv_dp_pkg::*;
#(
    parameter int IMG_SIZE  = DEF_IMG_SIZE,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int ADDR_W    = 12,
    parameter int GLB_CNT_W = DEF_GLB_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CMD_FLAG_W-1:0]    cmd_flags,
    input  logic                     dp_cnt_rst,
    input  logic [GLB_CNT_W-1:0]     glb_idx_x,
    input  logic [GLB_CNT_W-1:0]     glb_idx_y,
    output logic [INT_FLAG_W-1:0]    fb_flags,
    output logic                     w_rd,
    output logic [3:0]               w_addr,
    input  logic signed [DATA_W-1:0] w_rdata,
    output logic                     img_rd,
    output logic [ADDR_W-1:0]        img_addr,
    input  logic [DATA_W-1:0]        img_rdata,
    output logic                     out_wr,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic                     done
);

    logic                     run_p0;
    logic [CNT_W-1:0]         cnt_p0;
    logic                     pix_ok_p0;
    logic signed [DATA_W-1:0] wgt_p0 [9];
    logic [DATA_W-1:0]        pix_p0 [9];

    phase_e                   ph;
    logic                     cnt_last, cnt_win, in_img, x_ok, y_ok;
    logic [31:0]              row, col;
    logic [CNT_W-1:0]         cap_idx, mac_idx;
    logic                     mac_clr, mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic [DATA_W-1:0]        sat;

    // run_p0 keeps the datapath idle for the first cycle after reset.
    always_comb begin
        ph       = (run_p0 && !reset) ? decode_cmd(cmd_flags) : PH_ILLEGAL;
        cnt_last = cnt_p0 == CNT_W'(CNT_LAST);
        cnt_win  = cnt_p0 < CNT_W'(CNT_LAST);
        row      = 32'(glb_idx_y) + 32'(cnt_p0 / CNT_W'(3));
        col      = 32'(glb_idx_x) + 32'(cnt_p0 % CNT_W'(3));
        in_img   = (row < 32'(IMG_SIZE)) && (col < 32'(IMG_SIZE));
        x_ok     = 32'(glb_idx_x) <= 32'(IMG_SIZE - 3);
        y_ok     = 32'(glb_idx_y) <= 32'(IMG_SIZE - 3);
        cap_idx  = cnt_p0 - CNT_W'(1);
        mac_idx  = cnt_win ? cnt_p0 : '0;
        mac_clr  = (ph == PH_OPT) && (cnt_p0 == '0);
        mac_en   = (ph == PH_OPT) && (cnt_p0 != '0) && cnt_win;
    end

    always_comb begin
        w_rd     = (ph == PH_READ_W) && cnt_win;
        w_addr   = w_rd ? cnt_p0 : '0;
        img_rd   = (ph == PH_READ) && cnt_win && in_img;
        img_addr = ((ph == PH_READ) && cnt_win) ? ADDR_W'(row * 32'(IMG_SIZE) + col) : '0;
        out_wr   = (ph == PH_WRITE) && x_ok && y_ok;
        out_addr = (ph == PH_WRITE)
                 ? ADDR_W'(32'(glb_idx_y) * 32'(IMG_SIZE - 2) + 32'(glb_idx_x)) : '0;
        out_data = (ph == PH_WRITE) ? sat : '0;
        done     = ph == PH_END;
        fb_flags             = '0;
        fb_flags[INT_READ_W] = (ph == PH_READ_W) && cnt_last;
        fb_flags[INT_READ]   = (ph == PH_READ) && cnt_last;
        fb_flags[INT_OPT]    = (ph == PH_OPT) && cnt_last;
        fb_flags[INT_WRITE]  = ph == PH_WRITE;
    end

    // Capture stage: memory data arrives one cycle after its strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_p0    <= 1'b0;
            cnt_p0    <= '0;
            pix_ok_p0 <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                wgt_p0[i] <= '0;
                pix_p0[i] <= '0;
            end
        end else begin
            run_p0    <= 1'b1;
            pix_ok_p0 <= img_rd;
            if (dp_cnt_rst)
                cnt_p0 <= '0;
            else if ((ph == PH_READ_W || ph == PH_READ || ph == PH_OPT) && !cnt_last)
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            if (ph == PH_READ_W && cnt_p0 != '0)
                wgt_p0[cap_idx] <= w_rdata;
            if (ph == PH_READ && cnt_p0 != '0)
                pix_p0[cap_idx] <= pix_ok_p0 ? img_rdata : '0;
        end
    end

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .pix   (pix_p0[mac_idx]),
        .wgt   (wgt_p0[mac_idx]),
        .acc   (acc),
        .sat   (sat)
    );

endmodule

// File: tb/tb_conv_dp.sv
// Self-checking bench for conv_dp (IMG_SIZE=8) with behavioural memories and
// a window-sum reference model; honours CONV_RELU_EN for expected outputs.
module tb_conv_dp;
    import conv_dp_pkg::*;

    localparam int IMG = 8;
    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int GW  = 6;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [CMD_FLAG_W-1:0] cmd_flags;
    logic                  dp_cnt_rst;
    logic [GW-1:0]         glb_idx_x, glb_idx_y;
    logic [INT_FLAG_W-1:0] fb_flags;
    logic                  w_rd;
    logic [3:0]            w_addr;
    logic signed [DW-1:0]  w_rdata;
    logic                  img_rd;
    logic [AW-1:0]         img_addr;
    logic [DW-1:0]         img_rdata;
    logic                  out_wr;
    logic [AW-1:0]         out_addr;
    logic [DW-1:0]         out_data;
    logic                  done;

    conv_dp #(
        .IMG_SIZE  (IMG),
        .DATA_W    (DW),
        .ACC_W     (20),
        .ADDR_W    (AW),
        .GLB_CNT_W (GW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_flags  (cmd_flags),
        .dp_cnt_rst (dp_cnt_rst),
        .glb_idx_x  (glb_idx_x),
        .glb_idx_y  (glb_idx_y),
        .fb_flags   (fb_flags),
        .w_rd       (w_rd),
        .w_addr     (w_addr),
        .w_rdata    (w_rdata),
        .img_rd     (img_rd),
        .img_addr   (img_addr),
        .img_rdata  (img_rdata),
        .out_wr     (out_wr),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .done       (done)
    );

    always #5 clk = ~clk;

    int wmem [9];
    int imem [IMG*IMG];
    int n_checks = 0;
    int n_fail   = 0;

    int wrd_log [16];
    int waddr_log [16];
    int ird_log [16];
    int iaddr_log [16];

    typedef struct {
        int x;
        int y;
        int exp_wr;
        int exp_addr;
        int exp_data;
    } vec_t;
    vec_t vecs [10];

    // One-cycle-latency memories; unstrobed cycles return garbage.
    always @(posedge clk) begin
        w_rdata   <= w_rd   ? DW'(wmem[int'(w_addr) % 9]) : DW'($urandom);
        img_rdata <= img_rd ? DW'(imem[int'(img_addr) % (IMG*IMG)]) : DW'($urandom);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_acc(input int x, input int y);
        int s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (y + r < IMG && x + c < IMG)
                    s += imem[(y + r) * IMG + x + c] * wmem[r * 3 + c];
        return s;
    endfunction

    function automatic int model_out(input int a);
        int v = a;
`ifdef CONV_RELU_EN
        if (v < 0) v = 0;
        else if (v > 255) v = 255;
`else
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
`endif
        return v & 255;
    endfunction

    task automatic run_cmd(input int cbit, input int fbit, output int lat);
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            if (cbit == CMD_READ_W) begin wrd_log[k] = -1; waddr_log[k] = -1; end
            if (cbit == CMD_READ)   begin ird_log[k] = -1; iaddr_log[k] = -1; end
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cmd_flags  = CMD_FLAG_W'(1 << cbit);
            dp_cnt_rst = 1'b0;
            #1;
            if (cbit == CMD_READ_W) begin wrd_log[k] = int'(w_rd); waddr_log[k] = int'(w_addr); end
            if (cbit == CMD_READ)   begin ird_log[k] = int'(img_rd); iaddr_log[k] = int'(img_addr); end
            if (fb_flags != '0) begin
                check("phase_flag_bits", fb_flags, 1 << fbit);
                lat        = k;
                dp_cnt_rst = 1'b1;
                break;
            end
        end
    endtask

    task automatic conv_run(input int x, input int y, output int wr, output int addr, output int data);
        int lat;
        @(negedge clk);
        cmd_flags  = CMD_FLAG_W'(1 << CMD_WAIT);
        dp_cnt_rst = 1'b0;
        glb_idx_x  = GW'(x);
        glb_idx_y  = GW'(y);
        run_cmd(CMD_READ_W, INT_READ_W, lat);
        check("read_w_latency", lat, 9);
        run_cmd(CMD_READ, INT_READ, lat);
        check("read_latency", lat, 9);
        run_cmd(CMD_OPT, INT_OPT, lat);
        check("opt_latency", lat, 9);
        @(negedge clk);
        cmd_flags  = CMD_FLAG_W'(1 << CMD_WRITE);
        dp_cnt_rst = 1'b0;
        #1;
        check("write_flag", fb_flags, 1 << INT_WRITE);
        wr   = int'(out_wr);
        addr = int'(out_addr);
        data = int'(out_data);
    endtask

    task automatic rand_inputs();
        cmd_flags  = CMD_FLAG_W'(1 << $urandom_range(1, 5));
        dp_cnt_rst = 1'($urandom);
        glb_idx_x  = GW'($urandom);
        glb_idx_y  = GW'($urandom);
    endtask

    initial begin
        int wr, addr, data, lat;
        int exp_iaddr [9];

        // Reset for two edges under random inputs.
        reset = 1'b1;
        rand_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rand_inputs();
        #1;
        check("rst_fb_flags", fb_flags, 0);
        check("rst_w_rd", w_rd, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_img_rd", img_rd, 0);
        check("rst_img_addr", img_addr, 0);
        check("rst_out_wr", out_wr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);

        // Weight ramp, unit pixels, window at (2,3).
        for (int i = 0; i < 9; i++) wmem[i] = i + 1;
        for (int i = 0; i < IMG*IMG; i++) imem[i] = 1;
        exp_iaddr = '{26, 27, 28, 34, 35, 36, 42, 43, 44};
        conv_run(2, 3, wr, addr, data);
        for (int k = 0; k < 9; k++) begin
            check("read_w_strobe", wrd_log[k], 1);
            check("read_w_addr", waddr_log[k], k);
            check("read_strobe", ird_log[k], 1);
            check("read_addr", iaddr_log[k], exp_iaddr[k]);
        end
        check("read_w_strobe_end", wrd_log[9], 0);
        check("ramp_out_wr", wr, 1);
        check("ramp_out_addr", addr, 20);
        check("ramp_out_data", data, 45);

        // Saturation extremes.
        for (int i = 0; i < IMG*IMG; i++) imem[i] = 255;
        for (int i = 0; i < 9; i++) wmem[i] = -128;
        conv_run(0, 0, wr, addr, data);
`ifdef CONV_RELU_EN
        check("sat_neg_data", data, 0);
`else
        check("sat_neg_data", data, 128);
`endif
        for (int i = 0; i < 9; i++) wmem[i] = 1;
        conv_run(1, 1, wr, addr, data);
`ifdef CONV_RELU_EN
        check("sat_pos_data", data, 255);
`else
        check("sat_pos_data", data, 127);
`endif

        // Right-edge window: out-of-image columns read as zero.
        for (int i = 0; i < IMG*IMG; i++) imem[i] = int'($urandom_range(1, 255));
        for (int i = 0; i < 9; i++) wmem[i] = int'($urandom_range(0, 255)) - 128;
        conv_run(7, 0, wr, addr, data);
        for (int k = 0; k < 9; k++)
            check("edge_read_strobe", ird_log[k], (k % 3 == 0) ? 1 : 0);
        check("edge_out_wr", wr, 0);
        check("edge_out_addr", addr, 7);
        check("edge_out_data", data, model_out(model_acc(7, 0)));

        // dp_cnt_rst at cnt=4 restarts the window walk.
        @(negedge clk);
        cmd_flags  = CMD_FLAG_W'(1 << CMD_WAIT);
        dp_cnt_rst = 1'b0;
        glb_idx_x  = GW'(2);
        glb_idx_y  = GW'(3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cmd_flags  = CMD_FLAG_W'(1 << CMD_READ);
            dp_cnt_rst = (k == 4);
            #1;
            if (k == 4) check("restart_pre_addr", img_addr, 35);
        end
        run_cmd(CMD_READ, INT_READ, lat);
        check("restart_first_addr", iaddr_log[0], 26);
        check("restart_latency", lat, 9);

        // Illegal commands idle the datapath and hold cnt.
        @(negedge clk);
        cmd_flags  = CMD_FLAG_W'(1 << CMD_WAIT);
        dp_cnt_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmd_flags  = CMD_FLAG_W'(1 << CMD_READ);
            dp_cnt_rst = 1'b0;
        end
        @(negedge clk);
        cmd_flags = 6'b000110;
        #1;
        check("illegal_multi_quiet", {fb_flags, w_rd, img_rd, out_wr, done}, 0);
        @(negedge clk);
        cmd_flags = '0;
        #1;
        check("illegal_zero_quiet", {fb_flags, w_rd, img_rd, out_wr, done}, 0);
        @(negedge clk);
        cmd_flags = CMD_FLAG_W'(1 << CMD_READ);
        #1;
        check("illegal_hold_addr", img_addr, 34);
        @(negedge clk);
        cmd_flags  = CMD_FLAG_W'(1 << CMD_WAIT);
        dp_cnt_rst = 1'b1;

        // Reset in the middle of READ_W.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmd_flags  = CMD_FLAG_W'(1 << CMD_READ_W);
            dp_cnt_rst = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_quiet", {fb_flags, w_rd, img_rd, out_wr, done, w_addr}, 0);
        @(negedge clk);
        #1;
        check("midreset_restart", {w_rd, w_addr}, 16);
        @(negedge clk);
        cmd_flags  = CMD_FLAG_W'(1 << CMD_WAIT);
        dp_cnt_rst = 1'b1;

        // Random table of windows against the reference model.
        for (int i = 0; i < IMG*IMG; i++) imem[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) wmem[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < 10; i++) begin
            vecs[i].x = (i == 0) ? 5 : (i == 1) ? 6 : (i == 2) ? 0 : int'($urandom_range(0, IMG - 1));
            vecs[i].y = (i == 0) ? 5 : (i == 1) ? 5 : (i == 2) ? 7 : int'($urandom_range(0, IMG - 1));
            vecs[i].exp_wr   = (vecs[i].x <= IMG - 3 && vecs[i].y <= IMG - 3) ? 1 : 0;
            vecs[i].exp_addr = vecs[i].y * (IMG - 2) + vecs[i].x;
            vecs[i].exp_data = model_out(model_acc(vecs[i].x, vecs[i].y));
        end
        for (int i = 0; i < 10; i++) begin
            conv_run(vecs[i].x, vecs[i].y, wr, addr, data);
            check("vec_out_wr", wr, vecs[i].exp_wr);
            check("vec_out_addr", addr, vecs[i].exp_addr);
            check("vec_out_data", data, vecs[i].exp_data);
        end

        // END raises done with everything else quiet.
        @(negedge clk);
        cmd_flags  = CMD_FLAG_W'(1 << CMD_END);
        dp_cnt_rst = 1'b0;
        #1;
        check("end_done", done, 1);
        check("end_quiet", {fb_flags, w_rd, img_rd, out_wr}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
